// File: rtl/cache_pkg.sv
// cache_pkg: shared states, default geometry and one-hot helper for the cache controller
package cache_pkg;
  localparam int DEF_SETS = 4;
  localparam int DEF_WAYS = 4;
  localparam int DEF_ADDR_W = 8;
  localparam int IDX_W = $clog2(DEF_SETS);
  localparam int TAG_W = DEF_ADDR_W - IDX_W;
  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, REFILL, MEM_WR, RESP} cache_state_e;
  function automatic logic [31:0] onehot_lowest(input logic [31:0] v);
    return v & (~v + 32'd1);
  endfunction
endpackage

// File: rtl/cache_victim_sel.sv
// cache_victim_sel: per-set round-robin pointers and first-invalid victim choice
module cache_victim_sel
  import cache_pkg::*;
#(
  parameter int SETS = DEF_SETS,
  parameter int WAYS = DEF_WAYS,
  localparam int IW = $clog2(SETS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IW-1:0]   index,
  input  logic [WAYS-1:0] valid_way,
  input  logic            advance,
  output logic [WAYS-1:0] victim,
  output logic            from_rr
);
  logic [WAYS-1:0] rr_ptr [SETS];
  always_ff @(posedge clk)
    if (rst) for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
    else if (advance) rr_ptr[index] <= rr_ptr[index] == WAYS'(WAYS - 1) ? '0 : rr_ptr[index] + WAYS'(1);
  always_comb begin
    from_rr = &valid_way;
    victim = from_rr ? WAYS'(1) << rr_ptr[index] : WAYS'(onehot_lowest(32'(~valid_way)));
  end
endmodule

// File: rtl/cache_ctrl_fsm.sv
// cache_ctrl_fsm: lookup/refill/write-through sequencer for a set-associative cache
module cache_ctrl_fsm
  import cache_pkg::*;
#(
  parameter int SETS = DEF_SETS,
  parameter int WAYS = DEF_WAYS,
  parameter int ADDR_W = DEF_ADDR_W,
  localparam int IW = $clog2(SETS),
  localparam int TW = ADDR_W - IW
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_ready,
  output logic              o_rsp_valid,
  output logic              o_rsp_hit,
  output logic [IW-1:0]     o_index,
  output logic [TW-1:0]     o_tag,
  input  logic [WAYS-1:0]   i_hit_way,
  input  logic [WAYS-1:0]   i_valid_way,
  output logic [WAYS-1:0]   o_way_sel,
  output logic [WAYS-1:0]   o_data_wr_en,
  output logic              o_tag_wr_en,
  output logic              o_mem_req,
  output logic              o_mem_we,
  input  logic              i_mem_ack,
  output logic              o_multi_hit
);
  cache_state_e state, nxt;
  logic we_q, hit_q, from_rr_q, hit, multi, from_rr;
  logic [IW-1:0] idx_q;
  logic [TW-1:0] tag_q;
  logic [WAYS-1:0] way_q, hw, victim;
  cache_victim_sel #(.SETS(SETS), .WAYS(WAYS)) u_victim (
    .clk(i_clk), .rst(i_rst), .index(idx_q), .valid_way(i_valid_way),
    .advance(state == REFILL && from_rr_q), .victim(victim), .from_rr(from_rr)
  );
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state <= IDLE;
      {we_q, hit_q, from_rr_q, o_multi_hit} <= '0;
      idx_q <= '0;
      tag_q <= '0;
      way_q <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && i_req) begin
        we_q <= i_we;
        idx_q <= i_addr[IW-1:0];
        tag_q <= i_addr[ADDR_W-1:IW];
      end
      // way_q remembers the hit way or the refill victim for REFILL and RESP
      if (state == LOOKUP) begin
        hit_q <= hit;
        way_q <= hit ? hw : victim;
        from_rr_q <= !hit && from_rr;
        if (multi) o_multi_hit <= 1'b1;
      end
    end
  always_comb begin
    hit = |i_hit_way;
    hw = WAYS'(onehot_lowest(32'(i_hit_way)));
    multi = ((i_hit_way & (i_hit_way - WAYS'(1))) != '0);
    nxt = state;
    case (state)
      IDLE:    nxt = i_req ? LOOKUP : IDLE;
      LOOKUP:  nxt = we_q ? MEM_WR : hit ? RESP : MEM_RD;
      MEM_RD:  nxt = i_mem_ack ? REFILL : MEM_RD;
      REFILL:  nxt = RESP;
      MEM_WR:  nxt = i_mem_ack ? RESP : MEM_WR;
      default: nxt = IDLE;
    endcase
    o_ready = state == IDLE;
    o_rsp_valid = state == RESP;
    o_rsp_hit = state == RESP && hit_q;
    o_index = idx_q;
    o_tag = tag_q;
    o_way_sel = state == LOOKUP && !we_q && hit ? hw : state == RESP && !we_q ? way_q : '0;
    o_data_wr_en = state == LOOKUP && we_q && hit ? hw : state == REFILL ? way_q : '0;
    o_tag_wr_en = state == REFILL;
    o_mem_req = state == MEM_RD || state == MEM_WR;
    o_mem_we = state == MEM_WR;
  end
endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// tb_cache_ctrl_fsm: scenario tasks with a response scoreboard for cache_ctrl_fsm
module tb_cache_ctrl_fsm;
  logic clk = 0, rst = 1, req = 0, we = 0, mem_ack = 0;
  logic [7:0] addr = '0;
  logic [3:0] hit_way = '0, valid_way = '0;
  logic ready, rsp_valid, rsp_hit, tag_wr_en, mem_req, mem_we, multi_hit;
  logic [1:0] index;
  logic [5:0] tag;
  logic [3:0] way_sel, data_wr_en;
  int n_checks = 0, n_fail = 0, cyc = 0;

  typedef struct packed {logic hit; logic [3:0] way;} exp_t;
  exp_t sb[$];

  typedef struct {
    int lat, wr_cyc, tag_cyc, mem_cyc, acc_cyc;
    logic [3:0] wr_or, way_lk, way_rs;
    logic mem_we_all, rhit;
    logic [1:0] idx_lk;
    logic [5:0] tag_lk;
  } obs_t;

  cache_ctrl_fsm dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr),
    .o_ready(ready), .o_rsp_valid(rsp_valid), .o_rsp_hit(rsp_hit),
    .o_index(index), .o_tag(tag), .i_hit_way(hit_way), .i_valid_way(valid_way),
    .o_way_sel(way_sel), .o_data_wr_en(data_wr_en), .o_tag_wr_en(tag_wr_en),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .i_mem_ack(mem_ack), .o_multi_hit(multi_hit)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk)
    if (!rst && rsp_valid) begin
      exp_t e;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_rsp: got response hit=%0b way=%0h, required no response", rsp_hit, way_sel);
      end else begin
        e = sb.pop_front();
        if (rsp_hit !== e.hit || way_sel !== e.way) begin
          n_fail++;
          $display("FAIL sb_rsp: got hit=%0b way=%0h, required hit=%0b way=%0h", rsp_hit, way_sel, e.hit, e.way);
        end
      end
    end

  task automatic run_req(input logic w, input logic [7:0] a, input logic [3:0] hw, input logic [3:0] vw,
                         input int ack_dly, output obs_t o);
    int wt = 0;
    logic done = 0;
    o = '{default: 0};
    o.mem_we_all = 1;
    @(negedge clk);
    while (!ready && wt < 20) begin
      @(negedge clk);
      wt++;
    end
    if (ready) begin
      req = 1; we = w; addr = a; hit_way = hw; valid_way = vw;
      @(posedge clk);
      #1 o.acc_cyc = cyc;
      req = 0;
      for (int c = 1; c <= 60 && !done; c++) begin
        @(negedge clk);
        if (c == 1) begin o.way_lk = way_sel; o.idx_lk = index; o.tag_lk = tag; end
        if (data_wr_en != 0) begin o.wr_or |= data_wr_en; o.wr_cyc++; end
        if (tag_wr_en) o.tag_cyc++;
        if (mem_req) begin o.mem_cyc++; if (!mem_we) o.mem_we_all = 0; end
        mem_ack = mem_req && o.mem_cyc == ack_dly;
        if (rsp_valid) begin
          o.lat = c; o.way_rs = way_sel; o.rhit = rsp_hit; mem_ack = 0; done = 1;
        end
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b, required 1", ready); end
    n_checks++; if ({rsp_valid, rsp_hit, mem_req, mem_we, tag_wr_en, multi_hit} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b, required 000000", {rsp_valid, rsp_hit, mem_req, mem_we, tag_wr_en, multi_hit}); end
    n_checks++; if ({data_wr_en, way_sel} !== 8'h00) begin n_fail++; $display("FAIL reset_ways: got %0h, required 0", {data_wr_en, way_sel}); end
    n_checks++; if ({index, tag} !== 8'h00) begin n_fail++; $display("FAIL reset_idx_tag: got %0h, required 0", {index, tag}); end
    rst = 0;
  endtask

  task automatic test_cold_miss;
    obs_t o;
    sb.push_back('{hit: 1'b0, way: 4'b0001});
    run_req(0, 8'h05, 4'b0000, 4'b0000, 3, o);
    n_checks++; if (o.lat !== 6) begin n_fail++; $display("FAIL cold_latency: got %0d, required 6", o.lat); end
    n_checks++; if (o.wr_or !== 4'b0001 || o.wr_cyc !== 1) begin n_fail++; $display("FAIL cold_wr_en: got %b x%0d, required 0001 x1", o.wr_or, o.wr_cyc); end
    n_checks++; if (o.tag_cyc !== 1) begin n_fail++; $display("FAIL cold_tag_wr: got %0d cycles, required 1", o.tag_cyc); end
    n_checks++; if (o.mem_cyc !== 3 || o.mem_we_all !== 1'b0) begin n_fail++; $display("FAIL cold_mem: got %0d cycles we=%0b, required 3 cycles we=0", o.mem_cyc, o.mem_we_all); end
    n_checks++; if (o.idx_lk !== 2'd1 || o.tag_lk !== 6'd1) begin n_fail++; $display("FAIL cold_idx_tag: got %0h/%0h, required 1/1", o.idx_lk, o.tag_lk); end
    n_checks++; if (o.rhit !== 1'b0) begin n_fail++; $display("FAIL cold_hit: got %0b, required 0", o.rhit); end
  endtask

  task automatic test_rr_wrap;
    obs_t o;
    logic [3:0] ev;
    for (int k = 0; k < 5; k++) begin
      ev = 4'b0001 << (k % 4);
      sb.push_back('{hit: 1'b0, way: ev});
      run_req(0, 8'(2 + 4 * k), 4'b0000, 4'b1111, 1, o);
      n_checks++; if (o.wr_or !== ev || o.lat !== 4) begin n_fail++; $display("FAIL rr_set2_victim%0d: got %b lat %0d, required %b lat 4", k, o.wr_or, o.lat, ev); end
    end
    sb.push_back('{hit: 1'b0, way: 4'b0001});
    run_req(0, 8'h10, 4'b0000, 4'b1111, 1, o);
    n_checks++; if (o.wr_or !== 4'b0001) begin n_fail++; $display("FAIL rr_set0_untouched: got %b, required 0001", o.wr_or); end
    sb.push_back('{hit: 1'b0, way: 4'b0001});
    run_req(0, 8'h05, 4'b0000, 4'b1111, 1, o);
    n_checks++; if (o.wr_or !== 4'b0001) begin n_fail++; $display("FAIL rr_set1_after_invalid_fill: got %b, required 0001", o.wr_or); end
    sb.push_back('{hit: 1'b0, way: 4'b0100});
    run_req(0, 8'h03, 4'b0000, 4'b1011, 1, o);
    n_checks++; if (o.wr_or !== 4'b0100 || o.tag_cyc !== 1) begin n_fail++; $display("FAIL first_invalid: got %b tag_wr x%0d, required 0100 x1", o.wr_or, o.tag_cyc); end
    sb.push_back('{hit: 1'b0, way: 4'b0001});
    run_req(0, 8'h07, 4'b0000, 4'b1111, 1, o);
    n_checks++; if (o.wr_or !== 4'b0001) begin n_fail++; $display("FAIL rr_set3_no_advance: got %b, required 0001", o.wr_or); end
  endtask

  task automatic test_read_hit;
    obs_t o;
    sb.push_back('{hit: 1'b1, way: 4'b0100});
    run_req(0, 8'h21, 4'b0100, 4'b1111, 1, o);
    n_checks++; if (o.lat !== 2) begin n_fail++; $display("FAIL hit_latency: got %0d, required 2", o.lat); end
    n_checks++; if (o.way_lk !== 4'b0100 || o.way_rs !== 4'b0100) begin n_fail++; $display("FAIL hit_way_sel: got %b/%b, required 0100/0100", o.way_lk, o.way_rs); end
    n_checks++; if (o.mem_cyc !== 0 || o.wr_cyc !== 0 || o.tag_cyc !== 0) begin
      n_fail++; $display("FAIL hit_side_effects: got mem %0d wr %0d tag %0d, required 0 0 0", o.mem_cyc, o.wr_cyc, o.tag_cyc); end
    n_checks++; if (o.rhit !== 1'b1) begin n_fail++; $display("FAIL hit_flag: got %0b, required 1", o.rhit); end
  endtask

  task automatic test_write;
    obs_t o;
    sb.push_back('{hit: 1'b1, way: 4'b0000});
    run_req(1, 8'h32, 4'b0010, 4'b1111, 5, o);
    n_checks++; if (o.wr_or !== 4'b0010 || o.wr_cyc !== 1) begin n_fail++; $display("FAIL whit_wr_en: got %b x%0d, required 0010 x1", o.wr_or, o.wr_cyc); end
    n_checks++; if (o.mem_cyc !== 5 || o.mem_we_all !== 1'b1) begin n_fail++; $display("FAIL whit_mem: got %0d cycles we=%0b, required 5 we=1", o.mem_cyc, o.mem_we_all); end
    n_checks++; if (o.lat !== 7 || o.tag_cyc !== 0) begin n_fail++; $display("FAIL whit_lat_tag: got lat %0d tag %0d, required 7 0", o.lat, o.tag_cyc); end
    sb.push_back('{hit: 1'b0, way: 4'b0000});
    run_req(1, 8'h47, 4'b0000, 4'b1111, 2, o);
    n_checks++; if (o.wr_cyc !== 0 || o.tag_cyc !== 0) begin n_fail++; $display("FAIL wmiss_no_write: got wr %0d tag %0d, required 0 0", o.wr_cyc, o.tag_cyc); end
    n_checks++; if (o.lat !== 4 || o.mem_cyc !== 2 || o.rhit !== 1'b0) begin
      n_fail++; $display("FAIL wmiss_flow: got lat %0d mem %0d hit %0b, required 4 2 0", o.lat, o.mem_cyc, o.rhit); end
    sb.push_back('{hit: 1'b0, way: 4'b0010});
    run_req(0, 8'h06, 4'b0000, 4'b1111, 1, o);
    n_checks++; if (o.wr_or !== 4'b0010) begin n_fail++; $display("FAIL rr_unchanged_by_hits: got %b, required 0010", o.wr_or); end
  endtask

  task automatic test_back_to_back;
    obs_t a, b;
    sb.push_back('{hit: 1'b1, way: 4'b0001});
    run_req(0, 8'h08, 4'b0001, 4'b1111, 1, a);
    sb.push_back('{hit: 1'b1, way: 4'b1000});
    run_req(0, 8'h0c, 4'b1000, 4'b1111, 1, b);
    n_checks++; if (b.acc_cyc - a.acc_cyc !== 3) begin n_fail++; $display("FAIL b2b_spacing: got %0d cycles, required 3", b.acc_cyc - a.acc_cyc); end
  endtask

  task automatic test_multi_hit;
    obs_t o;
    @(negedge clk);
    n_checks++; if (multi_hit !== 1'b0) begin n_fail++; $display("FAIL multi_pre: got %0b, required 0", multi_hit); end
    sb.push_back('{hit: 1'b1, way: 4'b0010});
    run_req(0, 8'h13, 4'b0110, 4'b1111, 1, o);
    n_checks++; if (o.way_lk !== 4'b0010 || o.lat !== 2) begin n_fail++; $display("FAIL multi_way: got %b lat %0d, required 0010 lat 2", o.way_lk, o.lat); end
    @(negedge clk);
    n_checks++; if (multi_hit !== 1'b1) begin n_fail++; $display("FAIL multi_set: got %0b, required 1", multi_hit); end
    sb.push_back('{hit: 1'b1, way: 4'b0001});
    run_req(0, 8'h14, 4'b0001, 4'b1111, 1, o);
    @(negedge clk);
    n_checks++; if (multi_hit !== 1'b1) begin n_fail++; $display("FAIL multi_sticky: got %0b, required 1", multi_hit); end
  endtask

  task automatic test_reset_abort;
    int wt = 0;
    logic bad = 0;
    @(negedge clk);
    req = 1; we = 0; addr = 8'h09; hit_way = 4'b0000; valid_way = 4'b1111;
    @(posedge clk);
    #1 req = 0;
    while (!mem_req && wt < 10) begin @(negedge clk); wt++; end
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL abort_reach_mem_rd: got mem_req %0b, required 1", mem_req); end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b0 || ready !== 1'b1 || tag_wr_en !== 1'b0 || data_wr_en !== 4'b0) begin
      n_fail++; $display("FAIL abort_next_cycle: got req %0b rdy %0b tag %0b wr %b, required 0 1 0 0000", mem_req, ready, tag_wr_en, data_wr_en); end
    n_checks++; if (multi_hit !== 1'b0) begin n_fail++; $display("FAIL abort_multi_clear: got %0b, required 0", multi_hit); end
    rst = 0;
    mem_ack = 1;
    @(negedge clk);
    mem_ack = 0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid || tag_wr_en || data_wr_en != 0 || mem_req || !ready) bad = 1;
      @(negedge clk);
    end
    n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL abort_late_ack: got activity %0b, required 0", bad); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_rr_wrap();
    test_read_hit();
    test_write();
    test_back_to_back();
    test_multi_hit();
    test_reset_abort();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d pending, required 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
